addr_decoder: RTL and testbench
===============================

ADDR_DECODER -- requirements
Module: addr_decoder

Interface
REQ-001 Parameter: ADDR_W, 25, linear address width.
REQ-002 Parameter: DIM_W, 15, row/column/stride width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset.
REQ-005 in_valid  input  1  request valid.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 addr  input  ADDR_W  linear address to decode.
REQ-008 width  input  DIM_W  row stride, captured at acceptance.
REQ-009 out_valid  output  1  result valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 row  output  DIM_W  decoded row = addr / width.
REQ-012 col  output  DIM_W  decoded column = addr % width.
REQ-013 err  output  1  result invalid (zero stride, row overflow, range fail).
REQ-014 finish_flag  output  1  one-cycle pulse when a result first becomes valid.

Function
REQ-015 The block SHALL invert the row*width+col address mapping: row = floor(addr/width), col = addr mod width.
REQ-016 FSM states SHALL be IDLE, DIV, DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 IDLE->DIV on in_valid&&in_ready with width!=0; addr and width SHALL be latched on that edge.
REQ-018 IDLE->DONE on handshake with width==0; result err=1, row=all-ones (0x7FFF), col=0; out_valid SHALL rise 1 cycle after acceptance.
REQ-019 DIV SHALL perform restoring division, one quotient bit per cycle, MSB first, ADDR_W iterations; DIV->DONE after the last iteration.
REQ-020 For width!=0, out_valid SHALL rise exactly ADDR_W+1 (26) cycles after the acceptance edge.
REQ-021 Quotient is ADDR_W bits; if quotient >= 2^DIM_W, err=1 and row SHALL saturate to 0x7FFF; col SHALL still equal the remainder.
REQ-022 Remainder is always < width and SHALL be output in DIM_W bits without truncation loss.
REQ-023 In DONE, row, col, err, out_valid SHALL hold stable until out_valid&&out_ready.
REQ-024 DONE->IDLE on out_ready; in_ready SHALL rise the following cycle (no same-cycle accept/return).
REQ-025 finish_flag SHALL be high exactly on the first cycle out_valid is high for each result.
REQ-026 addr/width input changes after acceptance SHALL NOT affect the in-flight result.

Reset
REQ-027 reset low at a clock edge SHALL force IDLE and clear out_valid, row, col, err, finish_flag and all divider state to 0.
REQ-028 in_ready SHALL be 0 while reset is low and 1 on the first cycle after reset deasserts.
REQ-029 Reset mid-DIV or mid-DONE SHALL discard the transaction with no output handshake.

Configuration
REQ-030 Macro ADDR_DECODER_RANGE_CHECK_EN: when defined, input port height (DIM_W) SHALL exist, be latched at acceptance, and err SHALL also assert when the unsaturated row >= height.
REQ-031 When undefined, height SHALL not exist and err SHALL reflect only zero stride and row overflow.

Structure
REQ-032 Package addr_dec_pkg SHALL hold ADDR_W, DIM_W defaults, the FSM state enum, and ROW_SAT (all-ones DIM_W).
REQ-033 One sub-module addr_div_core SHALL implement the iterative restoring divider (start, done, quotient, remainder); FSM and handshakes stay in addr_decoder.

Verification
REQ-034 width=640, addr=3217 -> row=5, col=17, err=0, out_valid 26 cycles after accept, finish_flag one cycle.
REQ-035 width=0, addr=1234 -> err=1, row=0x7FFF, col=0, out_valid 1 cycle after accept.
REQ-036 width=1, addr=0x1FFFFFF -> err=1, row=0x7FFF, col=0.
REQ-037 Result ready, out_ready held low 10 cycles -> outputs stable, in_ready=0, finish_flag pulses once; out_ready high -> in_ready=1 next cycle.
REQ-038 reset low at DIV cycle 10 -> next cycle all outputs 0, no result emitted; following request width=3, addr=10 -> row=3, col=1.
REQ-039 With ADDR_DECODER_RANGE_CHECK_EN: height=480, width=640, addr=307200 -> err=1, row=480; without the macro -> err=0, row=480, col=0.

Source files
------------

// File: rtl/addr_dec_pkg.sv
// Shared widths, FSM state encoding and saturation constant for the address decoder.
package addr_dec_pkg;

    localparam int unsigned DEF_ADDR_W = 25;
    localparam int unsigned DEF_DIM_W  = 15;

    localparam logic [DEF_DIM_W-1:0] ROW_SAT = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/addr_decoder_if.sv
// Request/result bus of addr_decoder; height exists only with ADDR_DECODER_RANGE_CHECK_EN.
interface addr_decoder_if
    import addr_dec_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] addr;
    logic [DIM_W-1:0]  width;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
    logic [DIM_W-1:0]  height;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DIM_W-1:0]  row;
    logic [DIM_W-1:0]  col;
    logic              err;
    logic              finish_flag;

    modport master (
        output in_valid, addr, width,
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        output height,
`endif
        output out_ready,
        input  in_ready, out_valid, row, col, err, finish_flag
    );

    modport slave (
        input  in_valid, addr, width,
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        input  height,
`endif
        input  out_ready,
        output in_ready, out_valid, row, col, err, finish_flag
    );

endinterface

// File: rtl/addr_div_core.sv
// Iterative restoring divider, one quotient bit per cycle MSB first; the first
// step is taken on the start edge so ADDR_W steps complete ADDR_W-1 edges later.
module addr_div_core
    import addr_dec_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dividend,
    input  logic [DIM_W-1:0]  divisor,
    output logic              done,
    output logic [ADDR_W-1:0] quotient,
    output logic [DIM_W-1:0]  remainder
);

    localparam int unsigned CNT_W = $clog2(ADDR_W + 1);

    logic [ADDR_W-1:0] quo_q;
    logic [DIM_W-1:0]  rem_q;
    logic [DIM_W-1:0]  dvsr_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              done_q;

    logic [ADDR_W-1:0] src_quo;
    logic [ADDR_W-1:0] quo_nx;
    logic [DIM_W-1:0]  src_rem;
    logic [DIM_W-1:0]  src_dvsr;
    logic [DIM_W-1:0]  rem_nx;
    logic [DIM_W:0]    trial;
    logic              ge;

    // One restoring step; quo register shifts dividend bits out and quotient bits in.
    always_comb begin
        src_quo  = start ? dividend : quo_q;
        src_rem  = start ? '0 : rem_q;
        src_dvsr = start ? divisor : dvsr_q;
        trial    = {src_rem, src_quo[ADDR_W-1]};
        ge       = (trial >= {1'b0, src_dvsr});
        rem_nx   = ge ? (trial[DIM_W-1:0] - src_dvsr) : trial[DIM_W-1:0];
        quo_nx   = {src_quo[ADDR_W-2:0], ge};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else if (start) begin
            quo_q  <= quo_nx;
            rem_q  <= rem_nx;
            dvsr_q <= divisor;
            cnt_q  <= CNT_W'(ADDR_W - 1);
            done_q <= 1'b0;
        end else if (cnt_q != '0) begin
            quo_q  <= quo_nx;
            rem_q  <= rem_nx;
            cnt_q  <= cnt_q - CNT_W'(1);
            done_q <= (cnt_q == CNT_W'(1));
        end else begin
            done_q <= 1'b0;
        end
    end

    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/addr_decoder.sv
// Linear address -> (row, col) decoder: row = addr / width, col = addr % width.
// Optional height range check under ADDR_DECODER_RANGE_CHECK_EN.
module addr_decoder
    import addr_dec_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DIM_W  = DEF_DIM_W
) (
    input  logic          clk,
    input  logic          reset,
    addr_decoder_if.slave bus
);

    localparam logic [DIM_W-1:0] ROW_MAX = '1;

    state_t            state_q, state_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;
    logic [DIM_W-1:0]  row_q, row_d;
    logic [DIM_W-1:0]  col_q, col_d;
    logic              err_q, err_d;
    logic              finish_q, finish_d;

    logic              accept_c;
    logic              start_c;
    logic              div_done;
    logic [ADDR_W-1:0] quotient;
    logic [DIM_W-1:0]  remainder;
    logic              ovf_c;
    logic              range_err_c;

`ifdef ADDR_DECODER_RANGE_CHECK_EN
    logic [DIM_W-1:0]  height_q, height_d;
`endif

    assign accept_c = bus.in_valid && in_ready_q;
    assign start_c  = accept_c && (bus.width != '0);
    assign ovf_c    = (quotient > ADDR_W'(ROW_MAX));

`ifdef ADDR_DECODER_RANGE_CHECK_EN
    assign range_err_c = (quotient >= ADDR_W'(height_q));
`else
    assign range_err_c = 1'b0;
`endif

    addr_div_core #(.ADDR_W(ADDR_W), .DIM_W(DIM_W)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (start_c),
        .dividend  (bus.addr),
        .divisor   (bus.width),
        .done      (div_done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        row_d       = row_q;
        col_d       = col_q;
        err_d       = err_q;
        finish_d    = 1'b0;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        height_d    = height_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept_c) begin
`ifdef ADDR_DECODER_RANGE_CHECK_EN
                    height_d = bus.height;
`endif
                    if (bus.width == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        finish_d    = 1'b1;
                        row_d       = ROW_MAX;
                        col_d       = '0;
                        err_d       = 1'b1;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                if (div_done) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    finish_d    = 1'b1;
                    row_d       = ovf_c ? ROW_MAX : quotient[DIM_W-1:0];
                    col_d       = remainder;
                    err_d       = ovf_c || range_err_c;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            err_q       <= 1'b0;
            finish_q    <= 1'b0;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
            height_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            row_q       <= row_d;
            col_q       <= col_d;
            err_q       <= err_d;
            finish_q    <= finish_d;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
            height_q    <= height_d;
`endif
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.row         = row_q;
    assign bus.col         = col_q;
    assign bus.err         = err_q;
    assign bus.finish_flag = finish_q;

endmodule

// File: tb/tb_addr_decoder.sv
// Directed self-checking bench for addr_decoder (honours ADDR_DECODER_RANGE_CHECK_EN).
module tb_addr_decoder;

    localparam int unsigned AW = 25;
    localparam int unsigned DW = 15;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    addr_decoder_if #(.ADDR_W(AW), .DIM_W(DW)) bus ();

    addr_decoder #(.ADDR_W(AW), .DIM_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Issue one request, scramble inputs after acceptance, wait for out_valid.
    task automatic do_req(input logic [AW-1:0] a, input logic [DW-1:0] w,
                          input logic [DW-1:0] h, output int lat, output logic fin);
        @(negedge clk);
        bus.addr     = a;
        bus.width    = w;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        bus.height   = h;
`endif
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.addr     = '1;
        bus.width    = 15'd7;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        bus.height   = 15'd1;
`else
        if (h != 15'd0) lat = 0;
`endif
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        fin = bus.finish_flag;
        if (lat >= 100) begin
            checks++;
            failures++;
            $display("FAIL req_timeout got=no_out_valid exp=out_valid addr=%0d width=%0d", a, w);
        end
    endtask

    task automatic drain();
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin failures++; $display("FAIL rst_in_ready got=%b exp=0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", bus.out_valid); end
        checks++; if ({bus.row, bus.col} !== 30'd0) begin failures++; $display("FAIL rst_row_col got=%h/%h exp=0/0", bus.row, bus.col); end
        checks++; if ({bus.err, bus.finish_flag} !== 2'b00) begin failures++; $display("FAIL rst_err_fin got=%b%b exp=00", bus.err, bus.finish_flag); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL rst_release_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_basic();
        int lat; logic fin;
        do_req(25'd3217, 15'd640, 15'd1000, lat, fin);
        checks++; if (lat != 26) begin failures++; $display("FAIL basic_latency got=%0d exp=26", lat); end
        checks++; if (bus.row !== 15'd5) begin failures++; $display("FAIL basic_row got=%0d exp=5", bus.row); end
        checks++; if (bus.col !== 15'd17) begin failures++; $display("FAIL basic_col got=%0d exp=17", bus.col); end
        checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", bus.err); end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL basic_finish got=%b exp=1", fin); end
        @(negedge clk);
        checks++; if (bus.finish_flag !== 1'b0) begin failures++; $display("FAIL basic_finish_pulse got=%b exp=0", bus.finish_flag); end
        drain();
        checks++; if ({bus.out_valid, bus.in_ready} !== 2'b01) begin failures++; $display("FAIL basic_return got=%b%b exp=01", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_zero_stride();
        int lat; logic fin;
        do_req(25'd1234, 15'd0, 15'd1000, lat, fin);
        checks++; if (lat != 1) begin failures++; $display("FAIL zero_latency got=%0d exp=1", lat); end
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b1, 15'h7FFF, 15'd0}) begin
            failures++; $display("FAIL zero_result got=%b/%h/%0d exp=1/7fff/0", bus.err, bus.row, bus.col); end
        checks++; if (fin !== 1'b1) begin failures++; $display("FAIL zero_finish got=%b exp=1", fin); end
        drain();
    endtask

    task automatic test_overflow();
        int lat; logic fin;
        do_req(25'h1FFFFFF, 15'd1, 15'd1000, lat, fin);
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b1, 15'h7FFF, 15'd0}) begin
            failures++; $display("FAIL ovf_w1 got=%b/%h/%0d exp=1/7fff/0", bus.err, bus.row, bus.col); end
        drain();
        do_req(25'd32767999, 15'd1000, 15'h7FFF, lat, fin);
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b0, 15'd32767, 15'd999}) begin
            failures++; $display("FAIL ovf_edge_max got=%b/%0d/%0d exp=0/32767/999", bus.err, bus.row, bus.col); end
        drain();
        do_req(25'd32768000, 15'd1000, 15'h7FFF, lat, fin);
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b1, 15'h7FFF, 15'd0}) begin
            failures++; $display("FAIL ovf_edge_sat got=%b/%h/%0d exp=1/7fff/0", bus.err, bus.row, bus.col); end
        drain();
    endtask

    task automatic test_hold();
        int lat; logic fin; int bad = 0; int pulses;
        do_req(25'd12345, 15'd100, 15'd1000, lat, fin);
        pulses = fin ? 1 : 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.finish_flag === 1'b1) pulses++;
            if ({bus.out_valid, bus.in_ready, bus.err, bus.row, bus.col} !== {1'b1, 1'b0, 1'b0, 15'd123, 15'd45}) bad++;
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL hold_stable got=%0d_bad_cycles exp=0 row=%0d col=%0d", bad, bus.row, bus.col); end
        checks++; if (pulses != 1) begin failures++; $display("FAIL hold_finish_count got=%0d exp=1", pulses); end
        drain();
        checks++; if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL hold_in_ready got=%b exp=1", bus.in_ready); end
    endtask

    task automatic test_reset_mid();
        int lat; logic fin; int seen = 0;
        @(negedge clk);
        bus.addr = 25'd1000; bus.width = 15'd7; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checks++; if ({bus.in_ready, bus.out_valid, bus.err, bus.finish_flag, bus.row, bus.col} !== 34'd0) begin
            failures++; $display("FAIL midrst_outputs got=%b%b%b%b/%h/%h exp=0", bus.in_ready, bus.out_valid, bus.err, bus.finish_flag, bus.row, bus.col); end
        reset = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) seen++;
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
        do_req(25'd10, 15'd3, 15'd1000, lat, fin);
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b0, 15'd3, 15'd1}) begin
            failures++; $display("FAIL midrst_next got=%b/%0d/%0d exp=0/3/1", bus.err, bus.row, bus.col); end
        drain();
    endtask

    task automatic test_range();
        int lat; logic fin;
        do_req(25'd307200, 15'd640, 15'd480, lat, fin);
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b1, 15'd480, 15'd0}) begin
            failures++; $display("FAIL range_hit got=%b/%0d/%0d exp=1/480/0", bus.err, bus.row, bus.col); end
`else
        checks++; if ({bus.err, bus.row, bus.col} !== {1'b0, 15'd480, 15'd0}) begin
            failures++; $display("FAIL range_off got=%b/%0d/%0d exp=0/480/0", bus.err, bus.row, bus.col); end
`endif
        drain();
    endtask

    task automatic test_back_to_back();
        int lat; logic fin;
        logic [AW-1:0] va [3] = '{25'd100, 25'd33554431, 25'd2};
        logic [DW-1:0] vw [3] = '{15'd7, 15'd32767, 15'd3};
        logic [DW-1:0] er [3] = '{15'd14, 15'd1024, 15'd0};
        logic [DW-1:0] ec [3] = '{15'd2, 15'd1023, 15'd2};
        for (int i = 0; i < 3; i++) begin
            do_req(va[i], vw[i], 15'h7FFF, lat, fin);
            checks++; if ({bus.err, bus.row, bus.col} !== {1'b0, er[i], ec[i]} || lat != 26) begin
                failures++; $display("FAIL b2b_%0d got=%b/%0d/%0d lat=%0d exp=0/%0d/%0d lat=26", i, bus.err, bus.row, bus.col, lat, er[i], ec[i]); end
            drain();
        end
    endtask

    initial begin
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.addr      = '0;
        bus.width     = '0;
`ifdef ADDR_DECODER_RANGE_CHECK_EN
        bus.height    = '0;
`endif
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_zero_stride();
        test_overflow();
        test_hold();
        test_reset_mid();
        test_range();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
